// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - state encoding and phase constants for the fetch controller
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

endpackage

// File: rtl/phase_decoder.sv
// rtl/phase_decoder.sv - 2-to-4 one-hot decode of the phase counter
module phase_decoder (
  input  logic [1:0] count_i,
  output logic [3:0] t_phase_o
);

  always_comb begin
    t_phase_o = 4'b0001 << count_i;
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - four-phase instruction fetch sequencer with PC, branch load and phase checking
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      count,
  input  logic            run,
  input  logic            halt_req,
  input  logic            ld_en,
  input  logic [PC_W-1:0] ld_addr,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      t_phase,
  output logic            ir_ld,
  output logic            pc_wrap,
  output logic            phase_err,
  output logic [1:0]      state
);

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic            ir_ld_q;
  logic            pc_wrap_q;
  logic            phase_err_q;
  logic [1:0]      prev_q;
  logic            prev_vld_q;

  logic [PC_W:0]   pc_inc_d;
  logic [1:0]      exp_count_d;
  logic            phase_ok_d;

  phase_decoder u_phase_decoder (
    .count_i   (count),
    .t_phase_o (t_phase)
  );

  // The carry out of the increment is the wrap indication.
  always_comb begin
    pc_inc_d    = {1'b0, pc_q} + {{PC_W{1'b0}}, 1'b1};
    exp_count_d = prev_q + 2'd1;
    phase_ok_d  = !prev_vld_q || (count == exp_count_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      ir_ld_q     <= 1'b0;
      pc_wrap_q   <= 1'b0;
      phase_err_q <= 1'b0;
      prev_q      <= T0;
      prev_vld_q  <= 1'b0;
    end else begin
      prev_q     <= count;
      prev_vld_q <= 1'b1;
      ir_ld_q    <= 1'b0;
      pc_wrap_q  <= 1'b0;
      if (!phase_ok_d) begin
        phase_err_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (phase_ok_d && run && (count == T0)) begin
            state_q <= ST_RUN;
            ir_ld_q <= 1'b1;
          end
        end
        ST_RUN: begin
          // A broken phase sequence abandons the instruction in flight.
          if (!phase_ok_d) begin
            state_q <= ST_IDLE;
          end else if (count == T0) begin
            ir_ld_q <= 1'b1;
          end else if (count == T3) begin
            if (ld_en) begin
              pc_q <= ld_addr;
            end else begin
              pc_q      <= pc_inc_d[PC_W-1:0];
              pc_wrap_q <= pc_inc_d[PC_W];
            end
            if (halt_req || !run) begin
              state_q <= ST_HALTED;
            end
          end
        end
        ST_HALTED: begin
          if (!run) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pc        = pc_q;
  assign ir_ld     = ir_ld_q;
  assign pc_wrap   = pc_wrap_q;
  assign phase_err = phase_err_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

  logic       clk;
  logic       reset;
  logic [1:0] count;
  logic       run;
  logic       halt_req;
  logic       ld_en;
  logic [7:0] ld_addr;
  logic [7:0] pc;
  logic [3:0] t_phase;
  logic       ir_ld;
  logic       pc_wrap;
  logic       phase_err;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;
  int pulses;

  pc_fetch_ctrl #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk       (clk),
    .reset     (reset),
    .count     (count),
    .run       (run),
    .halt_req  (halt_req),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .pc        (pc),
    .t_phase   (t_phase),
    .ir_ld     (ir_ld),
    .pc_wrap   (pc_wrap),
    .phase_err (phase_err),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a phase value, take one rising edge, land 1 time unit after it.
  task automatic cyc(input logic [1:0] c);
    count = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; count = 2'd0; run = 1'b0; halt_req = 1'b0;
    ld_en = 1'b0; ld_addr = 8'h00;
    #3;
    check("rst_pc", pc, 8'h00);
    check("rst_state", state, 2'd0);
    check("rst_ir_ld", ir_ld, 1'b0);
    check("rst_wrap", pc_wrap, 1'b0);
    check("rst_err", phase_err, 1'b0);
    check("rst_tphase0", t_phase, 4'b0001);
    count = 2'd2; #1;
    check("rst_tphase2", t_phase, 4'b0100);
    @(posedge clk); #1;
    reset = 1'b0;

    // three sequential instructions, halt on the third
    run = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 4; c++) begin
        halt_req = (i == 2 && c == 3);
        cyc(c[1:0]);
        if (ir_ld) pulses++;
        if (c == 0) check("seq_ir_ld_hi", ir_ld, 1'b1);
        if (c == 1) check("seq_ir_ld_lo", ir_ld, 1'b0);
        if (c == 3) check("seq_pc", pc, i + 1);
      end
    end
    check("seq_pulses", pulses, 3);
    check("seq_halted", state, 2'd2);
    halt_req = 1'b0; run = 1'b0;
    cyc(0);
    check("halt_to_idle", state, 2'd0);
    cyc(1); cyc(2);
    ld_en = 1'b1; ld_addr = 8'h55;
    cyc(3);
    check("idle_ld_ignored", pc, 8'h03);
    ld_en = 1'b0;

    // branch to 0xFF, then increment wraps
    run = 1'b1;
    cyc(0);
    check("start_run", state, 2'd1);
    cyc(1); cyc(2);
    ld_en = 1'b1; ld_addr = 8'hFF;
    cyc(3);
    ld_en = 1'b0;
    check("br_pc_ff", pc, 8'hFF);
    check("br_no_wrap", pc_wrap, 1'b0);
    cyc(0); cyc(1); cyc(2); cyc(3);
    check("wrap_pc", pc, 8'h00);
    check("wrap_pulse", pc_wrap, 1'b1);
    cyc(0);
    check("wrap_one_cycle", pc_wrap, 1'b0);
    check("wrap_next_ir", ir_ld, 1'b1);
    ld_en = 1'b1; ld_addr = 8'h77;
    cyc(1);
    check("ld_t1_ignored", pc, 8'h00);
    ld_en = 1'b0;
    cyc(2);
    ld_en = 1'b1; ld_addr = 8'h00;
    cyc(3);
    check("br_zero_pc", pc, 8'h00);
    check("br_zero_no_wrap", pc_wrap, 1'b0);
    ld_en = 1'b0;

    // branch together with halt
    cyc(0); cyc(1); cyc(2);
    ld_en = 1'b1; ld_addr = 8'h40; halt_req = 1'b1;
    cyc(3);
    check("brhalt_pc", pc, 8'h40);
    check("brhalt_state", state, 2'd2);
    ld_en = 1'b0; halt_req = 1'b0;
    cyc(0);
    check("halted_stays", state, 2'd2);
    check("halted_no_ir", ir_ld, 1'b0);
    run = 1'b0;
    cyc(1);
    check("halted_release", state, 2'd0);

    // halt requested early is deferred to the count==3 edge
    cyc(2); cyc(3);
    run = 1'b1;
    cyc(0);
    halt_req = 1'b1;
    cyc(1);
    check("defer_t1_state", state, 2'd1);
    cyc(2);
    check("defer_t2_pc", pc, 8'h40);
    cyc(3);
    check("defer_pc", pc, 8'h41);
    check("defer_state", state, 2'd2);
    halt_req = 1'b0; run = 1'b0;
    cyc(0);
    check("defer_idle", state, 2'd0);
    check("defer_pc_hold", pc, 8'h41);

    // phase sequence violation while running
    run = 1'b1;
    cyc(1); cyc(2); cyc(3); cyc(0);
    check("err_pre_run", state, 2'd1);
    cyc(1);
    cyc(0);
    check("err_flag", phase_err, 1'b1);
    check("err_state", state, 2'd0);
    check("err_pc", pc, 8'h41);
    check("err_no_ir", ir_ld, 1'b0);
    cyc(1); cyc(2); cyc(3); cyc(0);
    check("err_sticky", phase_err, 1'b1);
    check("err_restart", state, 2'd1);

    // asynchronous reset mid-instruction
    cyc(1); cyc(2);
    reset = 1'b1;
    #1;
    check("async_pc", pc, 8'h00);
    check("async_state", state, 2'd0);
    check("async_err", phase_err, 1'b0);
    check("async_ir", ir_ld, 1'b0);
    cyc(3);
    reset = 1'b0;
    pulses = 0;
    cyc(1); if (ir_ld) pulses++;
    cyc(2); if (ir_ld) pulses++;
    cyc(3); if (ir_ld) pulses++;
    check("post_rst_no_ir", pulses, 0);
    check("post_rst_pc", pc, 8'h00);
    check("post_rst_idle", state, 2'd0);
    cyc(0);
    check("post_rst_run", state, 2'd1);
    check("post_rst_ir", ir_ld, 1'b1);
    check("post_rst_err", phase_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
